// File: rtl/gpio_mmio_v2.sv
// gpio_mmio_v2: memory-mapped GPIO peripheral.
//   Output side : OUT_REGS read-back output registers with one-cycle update pulses.
//   Input side  : IN_CH channels sampled every cycle, change detect into a sticky
//                 W1C STATUS register, maskable registered interrupt.
// Optional macro GPIO_SYNC_EN: inputs pass through a two-flop synchroniser
// ahead of the sample register (3-edge input latency instead of 1).
module gpio_mmio_v2 #(
  parameter int OUT_REGS = 14,
  parameter int OUT_W    = 8,
  parameter int IN_CH    = 3,
  parameter int IN_W     = 16,
  parameter int ADDR_W   = 6,
  parameter int OUT_BASE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [31:0]               addr,
  input  logic [31:0]               dat_i,
  input  logic [IN_CH*IN_W-1:0]     in_i,
  output logic [31:0]               dat_o,
  output logic [OUT_REGS*OUT_W-1:0] out_o,
  output logic [OUT_REGS-1:0]       out_upd_o,
  output logic                      irq_o
);

  localparam logic [ADDR_W-1:0] STAT_IDX = ADDR_W'(IN_CH);
  localparam logic [ADDR_W-1:0] IEN_IDX  = ADDR_W'(IN_CH + 1);

  logic [ADDR_W-1:0]                w_idx;
  logic [IN_CH-1:0][IN_W-1:0]       w_in;
  logic [IN_CH-1:0][IN_W-1:0]       w_samp;
  logic [IN_CH-1:0][IN_W-1:0]       r_in_q;
  logic [IN_CH-1:0]                 w_chg, w_clr, w_stat_nxt, w_ien_nxt;
  logic [IN_CH-1:0]                 r_stat, r_ien;
  logic [OUT_REGS-1:0][OUT_W-1:0]   r_out;
  logic [OUT_REGS-1:0]              w_owr;
  logic                             w_unused;

  assign w_idx    = addr[ADDR_W-1:0];
  assign w_in     = in_i;
  assign out_o    = r_out;
  // Upper address/data bits are deliberately ignored by the decoder.
  assign w_unused = ^{addr, dat_i};

`ifdef GPIO_SYNC_EN
  logic [IN_CH-1:0][IN_W-1:0] r_sync1, r_sync2;
  // Two-flop synchroniser for asynchronous front-end inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_samp = r_sync2;
`else
  assign w_samp = w_in;
`endif

  // Per-channel change flag and per-register write decode.
  for (genvar k = 0; k < IN_CH; k++) begin : g_ch
    assign w_chg[k] = (w_samp[k] != r_in_q[k]);
  end
  for (genvar k = 0; k < OUT_REGS; k++) begin : g_or
    localparam logic [ADDR_W-1:0] OIDX = ADDR_W'(OUT_BASE + k);
    assign w_owr[k] = wr_en && (w_idx == OIDX);
  end

  // Set beats clear: a change arriving alongside a W1C of the same bit keeps it pending.
  assign w_clr      = (wr_en && (w_idx == STAT_IDX)) ? dat_i[IN_CH-1:0] : '0;
  assign w_stat_nxt = (r_stat & ~w_clr) | w_chg;
  assign w_ien_nxt  = (wr_en && (w_idx == IEN_IDX)) ? dat_i[IN_CH-1:0] : r_ien;

  // Input sampling, status, enable and interrupt state; sampling never pauses for bus writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q <= '0;
      r_stat <= '0;
      r_ien  <= '0;
      irq_o  <= 1'b0;
    end else begin
      r_in_q <= w_samp;
      r_stat <= w_stat_nxt;
      r_ien  <= w_ien_nxt;
      irq_o  <= |(w_stat_nxt & w_ien_nxt);
    end
  end

  // Output registers and their one-cycle update pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      out_upd_o <= '0;
    end else begin
      out_upd_o <= w_owr;
      for (int k = 0; k < OUT_REGS; k++)
        if (w_owr[k]) r_out[k] <= dat_i[OUT_W-1:0];
    end
  end

  // Read decode: combinational, no side effects; unmapped indices read 0.
  always_comb begin
    dat_o = '0;
    for (int k = 0; k < IN_CH; k++)
      if (w_idx == ADDR_W'(k)) dat_o[IN_W-1:0] = r_in_q[k];
    if (w_idx == STAT_IDX) dat_o[IN_CH-1:0] = r_stat;
    if (w_idx == IEN_IDX)  dat_o[IN_CH-1:0] = r_ien;
    for (int k = 0; k < OUT_REGS; k++)
      if (w_idx == ADDR_W'(OUT_BASE + k)) dat_o[OUT_W-1:0] = r_out[k];
  end

endmodule
